hazard_scoreboard: RTL

Parametrised RAW/WAW hazard unit for the ID stage of the RV64 pipeline. Per architectural register, it tracks writes that are in flight and not yet forwardable, and stalls ID while a source or destination register is still pending. Fixed-latency producers (ALU, load) are timed by per-register countdowns. Variable-latency producers (mul/div) are held until a completion strobe arrives. It sits between the decoder and the ID/EX pipeline register and also keeps a stall-cycle performance counter.

---
 rtl/hazard_scoreboard_pkg.sv | 23 ++
 rtl/hazard_scoreboard_sb_cnt_entry.sv | 31 +++
 rtl/hazard_scoreboard.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: latency classes
// coming from the decoder and the default register-file address width.
package hazard_scoreboard_pkg;

  // Default architectural register address width (32 integer registers)
  localparam int REG_ADDR_WIDTH_DEF = 5;

  // Latency class of the producer sitting in ID
  typedef enum logic [1:0] {
    LAT_CLS_ALU  = 2'd0,
    LAT_CLS_LOAD = 2'd1,
    LAT_CLS_LONG = 2'd2,
    LAT_CLS_RSVD = 2'd3
  } lat_cls_e;

  // Width needed to hold a countdown of 0..latMax, never narrower than 1 bit
  function automatic int cntWidth(input int latMax);
    int w;
    w = $clog2(latMax + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_cnt_entry.sv
// One per-register countdown. A nonzero count means the register's most
// recent fixed-latency write is still in flight and cannot be forwarded yet.
module sb_cnt_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_nonzero
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over a new load, a new load wins over the running decrement
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_nonzero = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW/WAW hazard scoreboard for the ID stage. Fixed-latency producers are
// tracked by per-register countdowns, one variable-latency (mul/div) producer
// is held in a single slot until its completion strobe, and a saturating
// counter records how many cycles ID spent stalled.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int LAT_ALU        = 0,
  parameter int LAT_LOAD       = 1,
  parameter int LAT_MAX        = 7,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic                      id_rs1_ren,
  input  logic                      id_rs2_ren,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rd_wen,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [1:0]                id_lat_class,
  input  logic                      long_done,
  input  logic [REG_ADDR_WIDTH-1:0] long_rd_addr,
  output logic                      stall,
  output logic                      long_busy,
  output logic                      sb_err,
  output logic [PERF_WIDTH-1:0]     stall_cycles
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int CNT_W    = cntWidth(LAT_MAX);

  localparam logic [CNT_W-1:0] LAT_ALU_V  = CNT_W'(LAT_ALU);
  localparam logic [CNT_W-1:0] LAT_LOAD_V = CNT_W'(LAT_LOAD);

  logic                      r_long_busy;
  logic [REG_ADDR_WIDTH-1:0] r_long_rd;
  logic                      r_sb_err;
  logic [PERF_WIDTH-1:0]     r_stall_cycles;

  logic [NUM_REGS-1:0]       w_cnt_nz;
  logic [NUM_REGS-1:1]       w_load;
  logic [CNT_W-1:0]          w_load_val;
  logic                      w_cls_long;
  logic                      w_cls_load;
  logic                      w_pend_rs1;
  logic                      w_pend_rs2;
  logic                      w_pend_rd;
  logic                      w_issue;
  logic                      w_wr;
  logic                      w_done_match;

  // x0 is never tracked, so its slot in the pending vector is tied low
  assign w_cnt_nz[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_cnt_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (flush),
      .i_load    (w_load[r]),
      .i_load_val(w_load_val),
      .o_nonzero (w_cnt_nz[r])
    );
  end

  // Decode latency class; the reserved encoding behaves like an ALU op
  always_comb begin
    w_cls_long = 1'b0;
    w_cls_load = 1'b0;
    case (lat_cls_e'(id_lat_class))
      LAT_CLS_LOAD: w_cls_load = 1'b1;
      LAT_CLS_LONG: w_cls_long = 1'b1;
      default:      ;
    endcase
  end

  // A register is pending while its countdown runs or while the outstanding
  // long op targets it; any reference to x0 is never pending
  always_comb begin
    w_pend_rs1 = 1'b0;
    w_pend_rs2 = 1'b0;
    w_pend_rd  = 1'b0;
    if (id_rs1_addr != '0) begin
      w_pend_rs1 = w_cnt_nz[id_rs1_addr] | (r_long_busy & (r_long_rd == id_rs1_addr));
    end
    if (id_rs2_addr != '0) begin
      w_pend_rs2 = w_cnt_nz[id_rs2_addr] | (r_long_busy & (r_long_rd == id_rs2_addr));
    end
    if (id_rd_addr != '0) begin
      w_pend_rd = w_cnt_nz[id_rd_addr] | (r_long_busy & (r_long_rd == id_rd_addr));
    end
  end

  // Stall on RAW for either source, WAW on rd, or a second long op while one is outstanding
  always_comb begin
    stall = 1'b0;
    if (id_valid) begin
      stall = (id_rs1_ren & w_pend_rs1) |
              (id_rs2_ren & w_pend_rs2) |
              (id_rd_wen  & w_pend_rd)  |
              (w_cls_long & r_long_busy);
    end
  end

  assign w_issue      = id_valid & ~stall & ~flush;
  assign w_wr         = w_issue & id_rd_wen & (id_rd_addr != '0);
  assign w_done_match = long_done & r_long_busy & (long_rd_addr == r_long_rd);

  // Steer a fixed-latency issue into the countdown of its destination register
  always_comb begin
    w_load     = '0;
    w_load_val = w_cls_load ? LAT_LOAD_V : LAT_ALU_V;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_load[r] = w_wr & ~w_cls_long & (id_rd_addr == REG_ADDR_WIDTH'(r));
    end
  end

  // Long-op slot: completion is applied before a same-cycle long issue
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_long_busy <= 1'b0;
      r_long_rd   <= '0;
    end else if (flush) begin
      r_long_busy <= 1'b0;
    end else begin
      if (w_done_match) begin
        r_long_busy <= 1'b0;
      end
      if (w_wr & w_cls_long) begin
        r_long_busy <= 1'b1;
        r_long_rd   <= id_rd_addr;
      end
    end
  end

  // Sticky error for a completion strobe that matches no outstanding long op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else if (long_done & ~w_done_match) begin
      r_sb_err <= 1'b1;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign long_busy    = r_long_busy;
  assign sb_err       = r_sb_err;
  assign stall_cycles = r_stall_cycles;

endmodule
